aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
Sequential AES-128 key-expansion engine: accepts a 128-bit cipher key and iterates the FIPS-197 expansion one round per clock. Stores all 11 round keys (round 0 to 10) in an internal register bank. Sits directly upstream of the cipher round datapath, which reads round keys by index once expansion completes. SubWord uses the codebase's existing sbox module (4 instances).

Parameters:
NR, 10, number of expansion rounds; only 10 (AES-128) is supported
KW, 128, key/round-key width in bits

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
key_in  input  128  cipher key; word w0 = key_in[127:96] ... w3 = key_in[31:0]
key_load  input  1  load request; sampled only when busy=0
busy  output  1  high while expansion is in progress
done  output  1  high when bank holds a complete, valid schedule
rk_addr  input  4  round-key index 0..10
rk_out  output  128  registered round key for rk_addr

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, rk_out=0, round counter=0, all bank entries=0.
- FSM states: IDLE, EXPAND, DONE.
- IDLE/DONE + key_load=1: bank[0]<=key_in, working key<=key_in, rc<=0, busy<=1, done<=0, go to EXPAND.
- EXPAND, each cycle: next = expand(working key, rcon(rc)); bank[rc+1]<=next; working key<=next; rc<=rc+1.
- expand: t = SubWord(RotWord(w3)) ^ rcon; n0=w0^t, n1=n0^w1, n2=n1^w2, n3=n2^w3.
- rcon(rc) for rc=0..9: 01,02,04,08,10,20,40,80,1b,36 in bits [31:24]; lower 24 bits zero.
- On the cycle writing bank[10] (rc=9): go to DONE; busy<=0, done<=1 next edge.
- Latency: key_load sampled at edge E -> busy high after E; bank[10] written at E+10; done=1 after E+10.
- key_load while busy=1: ignored; expansion continues undisturbed.
- key_load in DONE: restarts; done drops to 0 at the same edge busy rises.
- rk_out <= bank[rk_addr] every cycle (1-cycle read latency), including during EXPAND (partially written bank readable; content valid only for indices already written).
- rk_addr > 10: rk_out <= 0.
- rst asserted mid-EXPAND: immediate return to reset state; bank cleared; no partial done.
- busy and done never both 1.

Optional Feature:
Macro AES_KEY_STREAM_EN. When defined: add outputs rk_stream (128) and rk_stream_valid (1); rk_stream_valid pulses one cycle per round key written (11 pulses: round 0 on the load edge, then rounds 1..10) with rk_stream = the key written that edge, ordered 0..10; both reset to 0. When undefined: ports absent, no extra logic.

Test Plan:
- rst, load key 2b7e151628aed2a6abf7158809cf4f3c -> done after 10 cycles; rk_addr=1 -> a0fafe1788542cb123a339392a6c7605; rk_addr=2 -> f2c295f27a96b9435935807a7359f67f; rk_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Load all-zero key -> rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e, rk[0]=0.
- Pulse key_load with a different key at cycle 4 of EXPAND -> ignored; schedule equals first key's; done timing unchanged.
- rst asserted at cycle 5 of EXPAND -> busy=0, done=0, rk_out=0 immediately; all addresses read 0 after release.
- In DONE, load zero key -> done drops; after 10 cycles rk[10]=b4ef...188e; rk_addr=11..15 -> rk_out=0.
- With AES_KEY_STREAM_EN: FIPS key -> exactly 11 rk_stream_valid pulses, first = key_in, last = d014f9a8...0ca6.

Source files
------------

// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//
// Purpose:
//   Sequential AES-128 key expansion. A 128-bit cipher key is loaded and then
//   expanded one round per clock. All 11 round keys (0..10) are kept in an
//   internal register bank. The downstream cipher datapath reads them back by
//   index with a one-cycle registered read.
//
// Ports:
//   clk             in   1    system clock, rising edge
//   rst             in   1    asynchronous active-high reset
//   key_in          in   128  cipher key, w0 = key_in[127:96] .. w3 = key_in[31:0]
//   key_load        in   1    load request, honoured only while busy = 0
//   busy            out  1    expansion in progress
//   done            out  1    bank holds a complete, valid schedule
//   rk_addr         in   4    round-key index 0..10 (larger indices read as 0)
//   rk_out          out  128  registered round key for rk_addr
//
// Optional feature (macro AES_KEY_STREAM_EN):
//   rk_stream       out  128  round key written on the previous edge
//   rk_stream_valid out  1    one pulse per round key written, rounds 0..10
// ---------------------------------------------------------------------------

// AES S-box, computed as the GF(2^8) multiplicative inverse followed by the
// affine transform, so no 256-entry table has to be maintained.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] v;
        p = 8'h00;
        v = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ v;
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x4, x8, x16, x32, x64, x128;
    logic [7:0] inv;

    // a^254 is the inverse (and maps 0 to 0): 254 = 2+4+8+16+32+64+128.
    always_comb begin
        x2   = gf_mul(a, a);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
    end

    // Affine transform: inv ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    assign s = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

module aes_key_schedule #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] key_in,
    input  logic          key_load,
    output logic          busy,
    output logic          done,
    input  logic [3:0]    rk_addr,
    output logic [KW-1:0] rk_out
`ifdef AES_KEY_STREAM_EN
    ,
    output logic [KW-1:0] rk_stream,
    output logic          rk_stream_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_RC = 4'(NR - 1);

    state_t        state;
    logic [3:0]    rc;
    logic [KW-1:0] work;
    logic [KW-1:0] bank [0:10];

    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   rot;
    logic [31:0]   sub;
    logic [31:0]   t;
    logic [KW-1:0] next_key;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    assign w0  = work[127:96];
    assign w1  = work[95:64];
    assign w2  = work[63:32];
    assign w3  = work[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    sbox u_sbox3 (.a(rot[31:24]), .s(sub[31:24]));
    sbox u_sbox2 (.a(rot[23:16]), .s(sub[23:16]));
    sbox u_sbox1 (.a(rot[15:8]),  .s(sub[15:8]));
    sbox u_sbox0 (.a(rot[7:0]),   .s(sub[7:0]));

    // One FIPS-197 expansion step from the working key.
    always_comb begin
        t        = sub ^ {rcon(rc), 24'h000000};
        next_key = '0;
        next_key[127:96] = w0 ^ t;
        next_key[95:64]  = w0 ^ t ^ w1;
        next_key[63:32]  = w0 ^ t ^ w1 ^ w2;
        next_key[31:0]   = w0 ^ t ^ w1 ^ w2 ^ w3;
    end

    // Control FSM, round-key bank and registered read port. The read uses the
    // bank contents from before this edge's write, giving one cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            rc     <= 4'd0;
            work   <= '0;
            rk_out <= '0;
            for (int i = 0; i < 11; i++) bank[i] <= '0;
        end else begin
            if (rk_addr <= 4'd10) rk_out <= bank[rk_addr];
            else                  rk_out <= '0;

            case (state)
                IDLE, DONE: begin
                    if (key_load) begin
                        bank[0] <= key_in;
                        work    <= key_in;
                        rc      <= 4'd0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= EXPAND;
                    end
                end
                EXPAND: begin
                    bank[rc + 4'd1] <= next_key;
                    work            <= next_key;
                    rc              <= rc + 4'd1;
                    if (rc == LAST_RC) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_KEY_STREAM_EN
    // Mirrors every bank write: the load edge emits round 0, each expansion
    // edge emits the round just computed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_stream       <= '0;
            rk_stream_valid <= 1'b0;
        end else begin
            rk_stream_valid <= 1'b0;
            if ((state == IDLE || state == DONE) && key_load) begin
                rk_stream       <= key_in;
                rk_stream_valid <= 1'b1;
            end else if (state == EXPAND) begin
                rk_stream       <= next_key;
                rk_stream_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule
//
// Directed self-checking bench for aes_key_schedule using FIPS-197 and
// all-zero key vectors. Define AES_KEY_STREAM_EN to also exercise the
// round-key stream outputs.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ONES_KEY  = {128{1'b1}};

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         done;
    logic [3:0]   rk_addr;
    logic [127:0] rk_out;
`ifdef AES_KEY_STREAM_EN
    logic [127:0] rk_stream;
    logic         rk_stream_valid;
    int           stream_count;
    logic [127:0] stream_first;
    logic [127:0] stream_last;
`endif

    int n_checks;
    int n_fail;

    aes_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_load (key_load),
        .busy     (busy),
        .done     (done),
        .rk_addr  (rk_addr),
        .rk_out   (rk_out)
`ifdef AES_KEY_STREAM_EN
        ,
        .rk_stream       (rk_stream),
        .rk_stream_valid (rk_stream_valid)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no end of sequence, required end before 200000 ns");
        $fatal(1, "[TB] timeout");
    end

`ifdef AES_KEY_STREAM_EN
    // Records stream pulses away from the active edge
    always @(negedge clk) begin
        if (rk_stream_valid === 1'b1) begin
            if (stream_count == 0) stream_first = rk_stream;
            stream_last  = rk_stream;
            stream_count = stream_count + 1;
        end
    end
`endif

    // Advance n rising edges and settle 1 ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the load interface (called just after an edge)
    task automatic applyStimulus(input logic [127:0] key, input logic load);
        key_in   = key;
        key_load = load;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    // Present an address, wait for the registered read, then compare
    task automatic readKey(input logic [3:0] addr, input logic [127:0] expected,
                           input string tag);
        rk_addr = addr;
        step(1);
        checkOutput(tag, rk_out, expected);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        key_in   = '0;
        key_load = 1'b0;
        rk_addr  = 4'd0;
`ifdef AES_KEY_STREAM_EN
        stream_count = 0;
        stream_first = '0;
        stream_last  = '0;
`endif

        // Reset state
        step(2);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_done", 128'(done), 128'd0);
        checkOutput("reset_rk_out", rk_out, 128'd0);
        rst = 1'b0;
        step(1);

        // FIPS-197 key: busy right after the load edge, done after 10 more
        applyStimulus(FIPS_KEY, 1'b1);
        step(1);
        applyStimulus(FIPS_KEY, 1'b0);
        checkOutput("fips_busy_after_load", 128'(busy), 128'd1);
        checkOutput("fips_done_after_load", 128'(done), 128'd0);
        step(9);
        checkOutput("fips_busy_e9", 128'(busy), 128'd1);
        checkOutput("fips_done_e9", 128'(done), 128'd0);
        step(1);
        checkOutput("fips_busy_e10", 128'(busy), 128'd0);
        checkOutput("fips_done_e10", 128'(done), 128'd1);
        readKey(4'd0,  FIPS_KEY,  "fips_rk0");
        readKey(4'd1,  FIPS_RK1,  "fips_rk1");
        readKey(4'd2,  FIPS_RK2,  "fips_rk2");
        readKey(4'd3,  FIPS_RK3,  "fips_rk3");
        readKey(4'd10, FIPS_RK10, "fips_rk10");
`ifdef AES_KEY_STREAM_EN
        checkOutput("stream_count", 128'(stream_count), 128'd11);
        checkOutput("stream_first", stream_first, FIPS_KEY);
        checkOutput("stream_last", stream_last, FIPS_RK10);
`endif

        // Reload from DONE with the zero key: done drops as busy rises
        applyStimulus('0, 1'b1);
        step(1);
        applyStimulus('0, 1'b0);
        checkOutput("zero_busy_after_load", 128'(busy), 128'd1);
        checkOutput("zero_done_after_load", 128'(done), 128'd0);
        step(10);
        checkOutput("zero_done_e10", 128'(done), 128'd1);
        readKey(4'd0,  128'd0,    "zero_rk0");
        readKey(4'd1,  ZERO_RK1,  "zero_rk1");
        readKey(4'd10, ZERO_RK10, "zero_rk10");
        for (int a = 11; a < 16; a++)
            readKey(4'(a), 128'd0, $sformatf("out_of_range_rk%0d", a));

        // key_load mid-expansion is ignored
        applyStimulus(FIPS_KEY, 1'b1);
        step(1);
        applyStimulus(FIPS_KEY, 1'b0);
        step(3);
        applyStimulus(ONES_KEY, 1'b1);
        step(1);
        applyStimulus(ONES_KEY, 1'b0);
        step(5);
        checkOutput("ignore_busy_e9", 128'(busy), 128'd1);
        checkOutput("ignore_done_e9", 128'(done), 128'd0);
        step(1);
        checkOutput("ignore_done_e10", 128'(done), 128'd1);
        readKey(4'd0,  FIPS_KEY,  "ignore_rk0");
        readKey(4'd1,  FIPS_RK1,  "ignore_rk1");
        readKey(4'd10, FIPS_RK10, "ignore_rk10");

        // Reset mid-expansion clears everything at once
        rk_addr = 4'd0;
        applyStimulus(FIPS_KEY, 1'b1);
        step(1);
        applyStimulus(FIPS_KEY, 1'b0);
        step(4);
        checkOutput("pre_reset_rk_out", rk_out, FIPS_KEY);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", 128'(busy), 128'd0);
        checkOutput("midreset_done", 128'(done), 128'd0);
        checkOutput("midreset_rk_out", rk_out, 128'd0);
        step(1);
        rst = 1'b0;
        for (int a = 0; a <= 10; a++)
            readKey(4'(a), 128'd0, $sformatf("cleared_rk%0d", a));
        checkOutput("cleared_done", 128'(done), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
